// File: rtl/dircc_pkg.sv
// dircc_pkg: shared stream/host widths, control-register map and
// packet-source FSM states for the dircc mesh blocks.
package dircc_pkg;
   localparam int DIRCC_ST_DATA_W  = 32;
   localparam int DIRCC_ST_EMPTY_W = 2;
   localparam int DIRCC_MEM_DATA_W = 16;
   localparam logic [1:0] DIRCC_REG_LEN   = 2'd0;
   localparam logic [1:0] DIRCC_REG_EMPTY = 2'd1;
   localparam logic [1:0] DIRCC_REG_CTRL  = 2'd2;
   localparam int DIRCC_CTRL_START = 0;
   localparam int DIRCC_CTRL_CLEAR = 1;
   typedef enum logic [1:0] {ST_IDLE, ST_PREFETCH, ST_SEND} dircc_state_e;
   typedef struct packed {
      logic [DIRCC_ST_DATA_W-1:0] data;
      logic                       sop;
      logic                       eop;
   } dircc_beat_t;
endpackage

// File: rtl/dircc_packet_source_ram.sv
// dircc_packet_source_ram: word buffer as hi/lo 16-bit banks, one half-word
// write port and one registered 32-bit read port.
module dircc_packet_source_ram
   import dircc_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                        clk_i,
   input  logic                        we_i,
   input  logic                        whi_i,
   input  logic [ADDR_WIDTH-1:0]       waddr_i,
   input  logic [DIRCC_MEM_DATA_W-1:0] wdata_i,
   input  logic [ADDR_WIDTH-1:0]       raddr_i,
   output logic [DIRCC_ST_DATA_W-1:0]  rdata_o
);
   logic [DIRCC_MEM_DATA_W-1:0] hi_mem [2**ADDR_WIDTH];
   logic [DIRCC_MEM_DATA_W-1:0] lo_mem [2**ADDR_WIDTH];

   always_ff @(posedge clk_i) begin
      if (we_i && whi_i) hi_mem[waddr_i] <= wdata_i;
      if (we_i && !whi_i) lo_mem[waddr_i] <= wdata_i;
      rdata_o <= {hi_mem[raddr_i], lo_mem[raddr_i]};
   end
endmodule

// File: rtl/dircc_packet_source.sv
// dircc_packet_source: host-loaded Avalon-ST packet transmitter; the host fills
// the buffer, sets LEN/EMPTY and starts one packet sent under backpressure.
module dircc_packet_source
   import dircc_pkg::*;
#(
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk_clk,
   input  logic                  reset_reset_n,
   input  logic [ADDR_WIDTH+1:0] mem_address,
   input  logic                  mem_write,
   input  logic [15:0]           mem_writedata,
   output logic [15:0]           mem_readdata,
   output logic [31:0]           output_data,
   output logic                  output_valid,
   input  logic                  output_ready,
   output logic                  output_startofpacket,
   output logic                  output_endofpacket,
   output logic [1:0]            output_empty
);
   localparam logic [ADDR_WIDTH:0] DEPTH   = {1'b1, {ADDR_WIDTH{1'b0}}};
   localparam logic [ADDR_WIDTH:0] IDX_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   dircc_state_e state_q, state_d;
   logic [ADDR_WIDTH:0] len_q, len_d, idx_q, idx_d, iss_idx;
   logic [1:0] empty_q, empty_d, cnt_q;
   logic done_q, done_d, err_q, err_d;
   logic rvld_q, rsop_q, reop_q, wp_q, rp_q, host_buf_q, half_q;
   logic [15:0] ctrl_rd_q, ctrl_rd_d;
   logic [31:0] ram_rdata;
   logic [ADDR_WIDTH-1:0] ram_raddr;
   logic region, busy, cfg_wr, ctrl_wr, clr, start_ok, bad_wr, pop, last_acc, issue;
   logic [1:0] reg_idx;
   dircc_beat_t fifo_q [2];
   dircc_beat_t head;

   assign region   = mem_address[ADDR_WIDTH+1];
   assign reg_idx  = mem_address[2:1];
   assign busy     = state_q != ST_IDLE;
   assign cfg_wr   = mem_write && region && !busy;
   assign ctrl_wr  = mem_write && region && reg_idx == DIRCC_REG_CTRL;
   assign clr      = ctrl_wr && mem_writedata[DIRCC_CTRL_CLEAR];
   assign start_ok = ctrl_wr && mem_writedata[DIRCC_CTRL_START] && !busy && len_q != '0 && len_q <= DEPTH;
   assign bad_wr   = mem_write && busy && (!region || reg_idx == DIRCC_REG_LEN || reg_idx == DIRCC_REG_EMPTY);
   assign head     = fifo_q[rp_q];
   assign output_valid = cnt_q != 2'd0;
   assign pop      = output_valid && output_ready;
   assign last_acc = pop && head.eop;
   // Reads are issued only while the skid plus the in-flight RAM word stay below two entries
   assign issue    = start_ok || (busy && idx_q < len_q && ({1'b0, cnt_q} + {2'b0, rvld_q}) < ({2'b0, pop} + 3'd2));
   assign iss_idx  = start_ok ? '0 : idx_q;
   assign ram_raddr = start_ok ? '0 : busy ? idx_q[ADDR_WIDTH-1:0] : mem_address[ADDR_WIDTH:1];

   assign output_data          = output_valid ? head.data : '0;
   assign output_startofpacket = output_valid && head.sop;
   assign output_endofpacket   = output_valid && head.eop;
   assign output_empty         = (output_valid && head.eop) ? empty_q : 2'b0;
   assign mem_readdata = host_buf_q ? (half_q ? ram_rdata[31:16] : ram_rdata[15:0]) : ctrl_rd_q;

   dircc_packet_source_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
      .clk_i   (clk_clk),
      .we_i    (mem_write && !region && !busy),
      .whi_i   (mem_address[0]),
      .waddr_i (mem_address[ADDR_WIDTH:1]),
      .wdata_i (mem_writedata),
      .raddr_i (ram_raddr),
      .rdata_o (ram_rdata)
   );

   always_comb begin
      state_d   = start_ok ? ST_PREFETCH : (state_q == ST_PREFETCH) ? ST_SEND : last_acc ? ST_IDLE : state_q;
      len_d     = (cfg_wr && reg_idx == DIRCC_REG_LEN) ? mem_writedata[ADDR_WIDTH:0] : len_q;
      empty_d   = (cfg_wr && reg_idx == DIRCC_REG_EMPTY) ? mem_writedata[1:0] : empty_q;
      idx_d     = start_ok ? IDX_ONE : issue ? idx_q + IDX_ONE : idx_q;
      done_d    = last_acc || (done_q && !clr);
      err_d     = bad_wr || (ctrl_wr && mem_writedata[DIRCC_CTRL_START] && !start_ok) || (err_q && !clr);
      ctrl_rd_d = !region ? 16'h0 :
                  reg_idx == DIRCC_REG_LEN   ? 16'(len_q) :
                  reg_idx == DIRCC_REG_EMPTY ? 16'(empty_q) :
                  reg_idx == DIRCC_REG_CTRL  ? {13'b0, err_q, done_q, busy} : 16'h0;
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         empty_q    <= '0;
         idx_q      <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         rvld_q     <= 1'b0;
         rsop_q     <= 1'b0;
         reop_q     <= 1'b0;
         cnt_q      <= '0;
         wp_q       <= 1'b0;
         rp_q       <= 1'b0;
         host_buf_q <= 1'b0;
         half_q     <= 1'b0;
         ctrl_rd_q  <= '0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         empty_q    <= empty_d;
         idx_q      <= idx_d;
         done_q     <= done_d;
         err_q      <= err_d;
         rvld_q     <= issue;
         rsop_q     <= iss_idx == '0;
         reop_q     <= iss_idx == len_q - IDX_ONE;
         cnt_q      <= cnt_q + 2'(rvld_q) - 2'(pop);
         wp_q       <= wp_q ^ rvld_q;
         rp_q       <= rp_q ^ pop;
         host_buf_q <= !region && !busy;
         half_q     <= mem_address[0];
         ctrl_rd_q  <= ctrl_rd_d;
      end
   end

   always_ff @(posedge clk_clk) begin
      if (rvld_q) fifo_q[wp_q] <= '{data: ram_rdata, sop: rsop_q, eop: reop_q};
   end
endmodule

// File: tb/tb_dircc_packet_source.sv
// tb_dircc_packet_source: directed sequence with randomized data/backpressure,
// checked against a packet-level model of buffer, LEN/EMPTY and status bits.
module tb_dircc_packet_source;
   localparam int AW = 8;
   localparam int DEPTH = 1 << AW;

   logic clk_clk = 1'b0, reset_reset_n = 1'b0;
   logic [AW+1:0] mem_address = '0;
   logic mem_write = 1'b0;
   logic [15:0] mem_writedata = '0;
   logic [15:0] mem_readdata;
   logic [31:0] output_data;
   logic output_valid, output_startofpacket, output_endofpacket;
   logic output_ready = 1'b0;
   logic [1:0] output_empty;

   int vectors = 0, miscompares = 0;
   logic [31:0] mdl_mem [DEPTH];
   int mdl_len = 0;
   logic [1:0] mdl_empty = '0;
   logic mdl_err = 1'b0, mdl_done = 1'b0;
   logic [15:0] r;
   bit pattern [6] = '{1, 0, 0, 1, 0, 1};

   dircc_packet_source #(.ADDR_WIDTH(AW)) dut (
      .clk_clk              (clk_clk),
      .reset_reset_n        (reset_reset_n),
      .mem_address          (mem_address),
      .mem_write            (mem_write),
      .mem_writedata        (mem_writedata),
      .mem_readdata         (mem_readdata),
      .output_data          (output_data),
      .output_valid         (output_valid),
      .output_ready         (output_ready),
      .output_startofpacket (output_startofpacket),
      .output_endofpacket   (output_endofpacket),
      .output_empty         (output_empty)
   );

   always #5 clk_clk = ~clk_clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_clk);
      #1;
   endtask

   function automatic logic [AW+1:0] buf_a(input int w, input bit h);
      logic [AW-1:0] wi;
      wi = w[AW-1:0];
      return {1'b0, wi, h};
   endfunction

   function automatic logic [AW+1:0] ctrl_a(input int idx);
      logic [1:0] ri;
      ri = idx[1:0];
      return {1'b1, {(AW-2){1'b0}}, ri, 1'b0};
   endfunction

   function automatic logic [39:0] outs();
      return {3'b0, output_valid, output_data, output_startofpacket, output_endofpacket, output_empty};
   endfunction

   task automatic wr(input logic [AW+1:0] a, input logic [15:0] d);
      mem_address = a;
      mem_writedata = d;
      mem_write = 1'b1;
      tick();
      mem_write = 1'b0;
   endtask

   task automatic rd(input logic [AW+1:0] a, output logic [15:0] d);
      mem_address = a;
      mem_write = 1'b0;
      tick();
      d = mem_readdata;
   endtask

   task automatic load_word(input int w, input logic [31:0] v);
      wr(buf_a(w, 1'b0), v[15:0]);
      wr(buf_a(w, 1'b1), v[31:16]);
      mdl_mem[w] = v;
   endtask

   task automatic set_len(input int l);
      wr(ctrl_a(0), 16'(l));
      mdl_len = l % (2 * DEPTH);
   endtask

   task automatic set_empty(input logic [1:0] e);
      wr(ctrl_a(1), {14'b0, e});
      mdl_empty = e;
   endtask

   task automatic check_stat(input string tag, input logic busy);
      logic [15:0] s;
      rd(ctrl_a(2), s);
      check(tag, s, {13'b0, mdl_err, mdl_done, busy});
   endtask

   task automatic start_bad(input string tag);
      wr(ctrl_a(2), 16'h1);
      mdl_err = 1'b1;
      for (int i = 0; i < 4; i++) begin
         check({tag, "_novalid"}, output_valid, 1'b0);
         tick();
      end
      check_stat({tag, "_stat"}, 1'b0);
   endtask

   // mode: 0 ready always, 1 fixed toggle pattern, 2 random; intrude: 0 none,
   // 1 start while busy, 2 buffer write, 3 LEN write, 4 reset at beat 2
   task automatic run_pkt(input int mode, input int intrude, input logic [15:0] sw);
      int nacc, cyc, first_v, last_cyc;
      logic held;
      logic [39:0] held_b, obs, exp;
      bit rdy;
      nacc = 0; cyc = 0; first_v = -1; last_cyc = 0; held = 1'b0; held_b = '0;
      if (sw[1]) begin
         mdl_err = 1'b0;
         mdl_done = 1'b0;
      end
      wr(ctrl_a(2), sw);
      while (nacc < mdl_len && cyc < 4 * mdl_len + 40) begin
         obs = outs();
         if (held) check("stall_hold", obs, held_b);
         if (output_valid && first_v < 0) begin
            first_v = cyc;
            check("start_latency", cyc <= 1, 1'b1);
         end
         if (intrude == 4 && nacc == 2) begin
            reset_reset_n = 1'b0;
            #1;
            check("rst_async_outputs", outs(), '0);
            check("rst_async_rdata", mem_readdata, '0);
            return;
         end
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? pattern[cyc % 6] : bit'($urandom_range(0, 1));
         mem_write = 1'b0;
         if (cyc == 3 && intrude >= 1 && intrude <= 3) begin
            mem_address = (intrude == 1) ? ctrl_a(2) : (intrude == 2) ? buf_a(0, 1'b0) : ctrl_a(0);
            mem_writedata = (intrude == 1) ? 16'h1 : (intrude == 2) ? 16'hDEAD : 16'h7;
            mem_write = 1'b1;
            mdl_err = 1'b1;
         end
         output_ready = rdy;
         held = output_valid && !rdy;
         held_b = obs;
         if (output_valid && rdy) begin
            exp = {3'b0, 1'b1, mdl_mem[nacc], nacc == 0, nacc == mdl_len - 1,
                   (nacc == mdl_len - 1) ? mdl_empty : 2'b0};
            check("beat", obs, exp);
            nacc++;
            last_cyc = cyc;
         end
         tick();
         cyc++;
      end
      mem_write = 1'b0;
      check("beat_count", nacc, mdl_len);
      if (mode == 0) check("no_bubble", last_cyc - first_v + 1, mdl_len);
      output_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("no_extra_beat", output_valid, 1'b0);
         tick();
      end
      mdl_done = 1'b1;
      check_stat("stat_after_pkt", 1'b0);
   endtask

   initial begin
      repeat (2) tick();
      check("rst_outputs", outs(), '0);
      reset_reset_n = 1'b1;
      tick();
      check_stat("rst_stat", 1'b0);
      rd(ctrl_a(0), r); check("rst_len", r, '0);
      rd(ctrl_a(1), r); check("rst_empty", r, '0);

      for (int i = 0; i < 4; i++)
         load_word(i, {16'(16'h1111 + 16'h2222 * i), 16'(16'h2222 + 16'h2222 * i)});
      set_len(4);
      set_empty(2'd2);
      rd(ctrl_a(0), r); check("len_readback", r, 16'd4);
      rd(ctrl_a(1), r); check("empty_readback", r, 16'd2);
      rd(buf_a(2, 1'b1), r); check("buf_hi_readback", r, 16'h5555);
      rd(buf_a(3, 1'b0), r); check("buf_lo_readback", r, 16'h8888);
      run_pkt(0, 0, 16'h1);
      run_pkt(1, 0, 16'h1);
      run_pkt(2, 0, 16'h1);

      set_len(1);
      set_empty(2'd3);
      run_pkt(0, 0, 16'h1);
      run_pkt(2, 0, 16'h1);
      for (int i = 0; i < DEPTH; i++) load_word(i, $urandom);
      set_len(DEPTH);
      set_empty(2'd1);
      run_pkt(0, 0, 16'h1);
      run_pkt(2, 0, 16'h1);

      wr(ctrl_a(2), 16'h2);
      mdl_err = 1'b0;
      mdl_done = 1'b0;
      check_stat("clear_stat", 1'b0);
      set_len(0);
      start_bad("len0");
      wr(ctrl_a(2), 16'h2);
      mdl_err = 1'b0;
      check_stat("clear_after_len0", 1'b0);
      set_len(DEPTH + 1);
      start_bad("len_over");
      set_len(8);
      set_empty(2'd0);
      run_pkt(1, 0, 16'h3);
      run_pkt(1, 1, 16'h1);
      run_pkt(1, 2, 16'h3);
      rd(buf_a(0, 1'b0), r); check("buf_write_dropped", r, mdl_mem[0][15:0]);
      run_pkt(2, 3, 16'h3);
      rd(ctrl_a(0), r); check("len_write_dropped", r, 16'd8);

      set_len(4);
      set_empty(2'd2);
      run_pkt(0, 4, 16'h3);
      output_ready = 1'b0;
      repeat (2) tick();
      reset_reset_n = 1'b1;
      mdl_len = 0;
      mdl_empty = '0;
      mdl_err = 1'b0;
      mdl_done = 1'b0;
      tick();
      check_stat("stat_after_reset", 1'b0);
      rd(ctrl_a(0), r); check("len_after_reset", r, '0);
      for (int i = 0; i < 4; i++) load_word(i, $urandom);
      set_len(4);
      set_empty(2'd2);
      run_pkt(0, 0, 16'h1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
